// File: rtl/dwt_pkg.sv
// rtl/dwt_pkg.sv - tile geometry, component encoding and fetch FSM states for dwt_tile_fetch
package dwt_pkg;

  localparam int WORDS_ROW  = 64;
  localparam int ROWS       = 64;
  localparam int COMP_WORDS = 4096;
  localparam int NCOMP      = 3;
  localparam int AW         = 14;
  localparam int WORD_W     = 17;
  localparam int SMP_ROW    = 2 * WORDS_ROW;
  localparam int COL_W      = $clog2(WORDS_ROW);
  localparam int ROW_W      = $clog2(ROWS);
  localparam int OCOL_W     = $clog2(SMP_ROW);

  typedef enum logic [1:0] {
    COMP_Y = 2'd0,
    COMP_U = 2'd1,
    COMP_V = 2'd2
  } comp_e;

  localparam logic [1:0] LAST_COMP = 2'(NCOMP - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  function automatic logic [AW-1:0] word_addr(input logic [1:0] comp,
                                               input logic [ROW_W-1:0] row,
                                               input logic [COL_W-1:0] col);
    return AW'(32'(comp) * COMP_WORDS + 32'(row) * WORDS_ROW + 32'(col));
  endfunction

endpackage

// File: rtl/dwt_fetch_skid.sv
// rtl/dwt_fetch_skid.sv - two-word skid FIFO that unpacks each word into even then odd sample
module dwt_fetch_skid
  import dwt_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [WORD_W-1:0] push_word_i,
  output logic [1:0]        occ_o,
  output logic [7:0]        smp_o,
  output logic              valid_o,
  input  logic              ready_i
);

  logic [WORD_W-1:0] mem_q [2];
  logic [1:0]        cnt_q;
  logic              rd_q, wr_q, sel_q;
  logic              fire, pop;
  logic              unused_b16;

  assign valid_o    = (cnt_q != 2'd0);
  assign fire       = valid_o & ready_i;
  // A word is retired only once its odd (second) sample has been taken.
  assign pop        = fire & sel_q;
  assign occ_o      = cnt_q;
  assign smp_o      = sel_q ? mem_q[rd_q][15:8] : mem_q[rd_q][7:0];
  assign unused_b16 = mem_q[0][16] ^ mem_q[1][16];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 2'd0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      sel_q <= 1'b0;
    end else begin
      if (push_i) wr_q  <= ~wr_q;
      if (fire)   sel_q <= ~sel_q;
      if (pop)    rd_q  <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= push_word_i;
  end

endmodule

// File: rtl/dwt_tile_fetch.sv
// rtl/dwt_tile_fetch.sv - drains ping-pong tile banks into a Y/U/V sample stream for the DWT
// Optional DC level shift on smp_data when DWT_FETCH_DCSHIFT_EN is defined.
module dwt_tile_fetch
  import dwt_pkg::*;
(
  input  logic              clk_dwt,
  input  logic              rst_syn,
  input  logic              start,
  output logic [AW-1:0]     addrb_o1,
  output logic              enb_o1,
  input  logic [WORD_W-1:0] doutb_o1,
  output logic [AW-1:0]     addrb_o2,
  output logic              enb_o2,
  input  logic [WORD_W-1:0] doutb_o2,
  output logic [8:0]        smp_data,
  output logic              smp_valid,
  input  logic              smp_ready,
  output logic [1:0]        smp_comp,
  output logic              smp_eol,
  output logic              smp_eot,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  fetch_state_e      state_q, state_d;
  logic              bank_q, start_q, pending_q, pending_d, overrun_q, done_q, inflight_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q, orow_q;
  logic [1:0]        comp_q, ocomp_q;
  logic [OCOL_W-1:0] ocol_q;
  logic [1:0]        occ;
  logic [7:0]        smp_byte;
  logic [AW-1:0]     rd_addr;
  logic [WORD_W-1:0] rd_word;
  logic              start_edge, issue, last_word, fire, eol_c, eot_c, tile_end;

  assign start_edge = start & ~start_q;
  // Skid slots plus outstanding reads never exceed the two-word FIFO depth.
  assign issue      = (state_q == ST_FETCH) && (({1'b0, occ} + {2'b00, inflight_q}) < 3'd2);
  assign last_word  = (col_q == COL_W'(WORDS_ROW - 1)) && (row_q == ROW_W'(ROWS - 1)) &&
                      (comp_q == LAST_COMP);
  assign fire       = smp_valid & smp_ready;
  assign eol_c      = (ocol_q == OCOL_W'(SMP_ROW - 1));
  assign eot_c      = eol_c && (orow_q == ROW_W'(ROWS - 1)) && (ocomp_q == LAST_COMP);
  assign tile_end   = (state_q == ST_DRAIN) && fire && eot_c;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      ST_IDLE: begin
        if (start_edge || pending_q) begin
          state_d   = ST_FETCH;
          pending_d = 1'b0;
        end
      end
      ST_FETCH: begin
        if (issue && last_word) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (tile_end) begin
          if (start_edge || pending_q) begin
            state_d   = ST_FETCH;
            pending_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (start_edge && (state_q != ST_IDLE) && !tile_end) pending_d = 1'b1;
  end

  always_ff @(posedge clk_dwt) begin
    if (rst_syn) begin
      state_q    <= ST_IDLE;
      bank_q     <= 1'b0;
      start_q    <= 1'b0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      comp_q     <= '0;
      ocol_q     <= '0;
      orow_q     <= '0;
      ocomp_q    <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      start_q    <= start;
      done_q     <= tile_end;
      inflight_q <= issue;
      if (start_edge && pending_q) overrun_q <= 1'b1;
      if (tile_end) bank_q <= ~bank_q;
      if (issue) begin
        col_q <= col_q + 1'b1;
        if (col_q == COL_W'(WORDS_ROW - 1)) begin
          row_q <= row_q + 1'b1;
          if (row_q == ROW_W'(ROWS - 1))
            comp_q <= (comp_q == LAST_COMP) ? 2'd0 : comp_q + 2'd1;
        end
      end
      if (fire) begin
        ocol_q <= ocol_q + 1'b1;
        if (eol_c) begin
          orow_q <= orow_q + 1'b1;
          if (orow_q == ROW_W'(ROWS - 1))
            ocomp_q <= (ocomp_q == LAST_COMP) ? 2'd0 : ocomp_q + 2'd1;
        end
      end
    end
  end

  assign rd_addr  = word_addr(comp_q, row_q, col_q);
  assign addrb_o1 = bank_q ? '0 : rd_addr;
  assign addrb_o2 = bank_q ? rd_addr : '0;
  assign enb_o1   = issue & ~bank_q;
  assign enb_o2   = issue & bank_q;
  assign rd_word  = bank_q ? doutb_o2 : doutb_o1;

  dwt_fetch_skid u_skid (
    .clk_i       (clk_dwt),
    .rst_i       (rst_syn),
    .push_i      (inflight_q),
    .push_word_i (rd_word),
    .occ_o       (occ),
    .smp_o       (smp_byte),
    .valid_o     (smp_valid),
    .ready_i     (smp_ready)
  );

`ifdef DWT_FETCH_DCSHIFT_EN
  assign smp_data = {1'b0, smp_byte} - 9'd128;
`else
  assign smp_data = {1'b0, smp_byte};
`endif

  assign smp_comp = ocomp_q;
  assign smp_eol  = eol_c;
  assign smp_eot  = eot_c;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_dwt_tile_fetch.sv
// tb/tb_dwt_tile_fetch.sv - directed self-checking bench for dwt_tile_fetch
module tb_dwt_tile_fetch;

  logic        clk_dwt = 1'b0;
  logic        rst_syn, start, smp_ready;
  logic [13:0] addrb_o1, addrb_o2;
  logic        enb_o1, enb_o2;
  logic [16:0] doutb_o1 = '0;
  logic [16:0] doutb_o2 = '0;
  logic [8:0]  smp_data;
  logic        smp_valid, smp_eol, smp_eot, busy, done, overrun;
  logic [1:0]  smp_comp;

  logic [16:0] mem1 [16384];
  logic [16:0] mem2 [16384];

  int n_checks = 0;
  int n_fail   = 0;
  int cur_n    = 0;

  always #5 clk_dwt = ~clk_dwt;

  always @(posedge clk_dwt) begin
    if (enb_o1) doutb_o1 <= mem1[addrb_o1];
    if (enb_o2) doutb_o2 <= mem2[addrb_o2];
  end

  dwt_tile_fetch dut (
    .clk_dwt   (clk_dwt),
    .rst_syn   (rst_syn),
    .start     (start),
    .addrb_o1  (addrb_o1),
    .enb_o1    (enb_o1),
    .doutb_o1  (doutb_o1),
    .addrb_o2  (addrb_o2),
    .enb_o2    (enb_o2),
    .doutb_o2  (doutb_o2),
    .smp_data  (smp_data),
    .smp_valid (smp_valid),
    .smp_ready (smp_ready),
    .smp_comp  (smp_comp),
    .smp_eol   (smp_eol),
    .smp_eot   (smp_eot),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h at sample %0d", tag, obs, exp, cur_n);
    end
  endtask

  function automatic logic [12:0] model(input bit bank, input int n);
    logic [16:0] w;
    logic [7:0]  s;
    logic [8:0]  d;
    w = bank ? mem2[n / 2] : mem1[n / 2];
    s = (n % 2 == 1) ? w[15:8] : w[7:0];
`ifdef DWT_FETCH_DCSHIFT_EN
    d = {1'b0, s} - 9'd128;
`else
    d = {1'b0, s};
`endif
    return {d, 2'(n / 8192), (n % 128) == 127, n == 24575};
  endfunction

  task automatic stream(input int n0, input int n1, input bit rnd, input bit bank,
                        input int p_at, input int p_len);
    int n = n0;
    int cyc = 0;
    int plen_left = 0;
    bit pulsed = 1'b0;
    bit held = 1'b0;
    while (n < n1 && cyc < 3 * (n1 - n0) + 100) begin
      @(negedge clk_dwt);
      smp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (p_at >= 0 && !pulsed && n >= p_at) begin
        start = 1'b1;
        pulsed = 1'b1;
        plen_left = p_len;
      end
      if (pulsed) begin
        if (plen_left == 0) start = 1'b0;
        else plen_left--;
      end
      #1;
      cur_n = n;
      if (held) check("valid_hold", {31'd0, smp_valid}, 32'd1);
      check("idle_bank_en", {31'd0, bank ? enb_o1 : enb_o2}, 32'd0);
      check("done_quiet", {31'd0, done}, 32'd0);
      if (smp_valid) begin
        check("sample", {19'd0, smp_data, smp_comp, smp_eol, smp_eot}, {19'd0, model(bank, n)});
        if (smp_ready) n++;
      end
      held = smp_valid && !smp_ready;
      cyc++;
    end
    check("stream_count", n, n1);
  endtask

  task automatic tile_turn(input bit new_bank);
    @(posedge clk_dwt); #1;
    check("done_pulse", {31'd0, done}, 32'd1);
    check("busy_b2b", {31'd0, busy}, 32'd1);
    check("new_bank_en", {31'd0, new_bank ? enb_o2 : enb_o1}, 32'd1);
    check("new_bank_addr", {18'd0, new_bank ? addrb_o2 : addrb_o1}, 32'd0);
    check("old_bank_en", {31'd0, new_bank ? enb_o1 : enb_o2}, 32'd0);
    @(posedge clk_dwt); #1;
    check("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [8:0] e_even, e_odd;
`ifdef DWT_FETCH_DCSHIFT_EN
    e_even = 9'd127;
    e_odd  = 9'd0;
`else
    e_even = 9'd255;
    e_odd  = 9'd128;
`endif
    for (int k = 0; k < 16384; k++) begin
      mem1[k] = {1'b1, 8'(k) ^ 8'h5A, 8'(k)};
      mem2[k] = {1'b0, 8'(k) ^ 8'h5A, 8'(k)};
    end
    rst_syn = 1'b1;
    start = 1'b0;
    smp_ready = 1'b1;
    repeat (3) @(posedge clk_dwt);
    #1;
    check("rst_valid", {31'd0, smp_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_en", {30'd0, enb_o1, enb_o2}, 32'd0);
    check("rst_addr", {4'd0, addrb_o1, addrb_o2}, 32'd0);
    check("rst_flags", {28'd0, smp_comp, smp_eol, smp_eot}, 32'd0);

    // Tile A: bank o1, ready held high, extra start mid-tile becomes pending.
    @(negedge clk_dwt);
    rst_syn = 1'b0;
    start = 1'b1;
    @(posedge clk_dwt); #1;
    check("fetch_busy", {31'd0, busy}, 32'd1);
    check("first_rd", {17'd0, enb_o1, addrb_o1}, {17'd0, 1'b1, 14'd0});
    check("first_rd_o2", {31'd0, enb_o2}, 32'd0);
    check("lat1_valid", {31'd0, smp_valid}, 32'd0);
    @(posedge clk_dwt); #1;
    check("lat2_valid", {31'd0, smp_valid}, 32'd0);
    @(posedge clk_dwt); #1;
    check("lat3_valid", {31'd0, smp_valid}, 32'd1);
    start = 1'b0;
    stream(0, 24576, 1'b0, 1'b0, 100, 1);
    tile_turn(1'b1);
    check("ovr_after_a", {31'd0, overrun}, 32'd0);

    // Tile B: bank o2, random ready; a held start counts once, a second edge overruns.
    stream(0, 150, 1'b1, 1'b1, 50, 20);
    check("ovr_level", {31'd0, overrun}, 32'd0);
    stream(150, 24576, 1'b1, 1'b1, 200, 1);
    check("ovr_set", {31'd0, overrun}, 32'd1);
    tile_turn(1'b0);
    check("ovr_sticky", {31'd0, overrun}, 32'd1);

    // Tile C on o1, aborted by reset after 1000 samples.
    stream(0, 1000, 1'b0, 1'b0, -1, 0);
    rst_syn = 1'b1;
    @(posedge clk_dwt); #1;
    check("abort_valid", {31'd0, smp_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_addr", {18'd0, addrb_o1}, 32'd0);
    check("abort_en", {30'd0, enb_o1, enb_o2}, 32'd0);
    check("abort_overrun", {31'd0, overrun}, 32'd0);

    // Fresh start replays from sample 0 on o1; word 0 replaced by 16'h80FF.
    @(negedge clk_dwt);
    rst_syn = 1'b0;
    mem1[0] = 17'h080FF;
    smp_ready = 1'b1;
    start = 1'b1;
    @(posedge clk_dwt); #1;
    check("replay_rd", {17'd0, enb_o1, addrb_o1}, {17'd0, 1'b1, 14'd0});
    @(posedge clk_dwt); #1;
    check("replay_lat2", {31'd0, smp_valid}, 32'd0);
    @(posedge clk_dwt); #1;
    check("replay_lat3", {31'd0, smp_valid}, 32'd1);
    check("dc_even", {23'd0, smp_data}, {23'd0, e_even});
    @(posedge clk_dwt); #1;
    check("dc_odd_valid", {31'd0, smp_valid}, 32'd1);
    check("dc_odd", {23'd0, smp_data}, {23'd0, e_odd});
    stream(1, 300, 1'b0, 1'b0, -1, 0);
    check("level_no_ovr", {31'd0, overrun}, 32'd0);
    check("replay_busy", {31'd0, busy}, 32'd1);
    start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
